// File: rtl/booth_radix4_mult.sv
// Iterative radix-4 Booth multiplier with runtime signed/unsigned mode and start/ready/done handshake.
// Latency STEPS+1 edges from accept to done; start is only taken while ready=1, never queued.
module booth_radix4_mult #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      signed_mode,
  input  logic [DATA_WIDTH-1:0]     multiplicand,
  input  logic [DATA_WIDTH-1:0]     multiplier,
  output logic                      ready,
  output logic                      done,
  output logic [2*DATA_WIDTH-1:0]   product
);

  localparam int W         = DATA_WIDTH;
  localparam int XW        = (W % 2 == 0) ? W + 2 : W + 1;
  localparam int STEPS     = XW / 2;
  localparam int CNT_WIDTH = $clog2(STEPS + 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t               state, state_nx;
  logic [XW:0]          ac;
  logic [XW-1:0]        q_reg;
  logic                 q_m1;
  logic [XW:0]          m_ext;
  logic [CNT_WIDTH-1:0] cnt;

  logic                 accept;
  logic                 last_step;
  logic                 m_sx, q_sx;
  logic [XW:0]          m_load;
  logic [XW-1:0]        q_load;
  logic [XW:0]          m_dbl;
  logic [XW:0]          addend;
  logic [XW:0]          sum;
  logic [2*XW+1:0]      shifted;

  assign accept    = start & ready;
  assign last_step = (cnt == CNT_WIDTH'(STEPS - 1));

  // Extension to XW bits keeps unsigned values positive when seen as signed.
  assign m_sx   = signed_mode & multiplicand[W-1];
  assign q_sx   = signed_mode & multiplier[W-1];
  assign m_load = {{(XW + 1 - W){m_sx}}, multiplicand};
  assign q_load = {{(XW - W){q_sx}}, multiplier};

  assign m_dbl = {m_ext[XW-1:0], 1'b0};

  always_comb begin
    addend = '0;
    case ({q_reg[1:0], q_m1})
      3'b001, 3'b010: addend = m_ext;
      3'b011:         addend = m_dbl;
      3'b100:         addend = -m_dbl;
      3'b101, 3'b110: addend = -m_ext;
      default:        addend = '0;
    endcase
  end

  assign sum = ac + addend;
  // Arithmetic shift of {AC,Q,q-1} by two, with the freshly added AC.
  assign shifted = {sum[XW], sum[XW], sum, q_reg[XW-1:1]};

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    ready    = 1'b0;
    done     = 1'b0;
    case (state)
      S_IDLE: begin
        ready = 1'b1;
        if (start) state_nx = S_CALC;
      end
      S_CALC: begin
        if (last_step) state_nx = S_DONE;
      end
      S_DONE: begin
        ready    = 1'b1;
        done     = 1'b1;
        state_nx = start ? S_CALC : S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ac      <= '0;
      q_reg   <= '0;
      q_m1    <= 1'b0;
      m_ext   <= '0;
      cnt     <= '0;
      product <= '0;
    end else if (accept) begin
      ac      <= '0;
      q_reg   <= q_load;
      q_m1    <= 1'b0;
      m_ext   <= m_load;
      cnt     <= '0;
    end else if (state == S_CALC) begin
      ac    <= shifted[2*XW+1:XW+1];
      q_reg <= shifted[XW:1];
      q_m1  <= shifted[0];
      cnt   <= cnt + CNT_WIDTH'(1);
      if (last_step) product <= shifted[2*W:1];
    end
  end

endmodule

// File: tb/tb_booth_radix4_mult.sv
// Directed bench for booth_radix4_mult at W=8 and W=5 with hand-computed products.
module tb_booth_radix4_mult;

  logic        clk = 1'b0;
  logic        rst;
  logic        start8, sm8, ready8, done8;
  logic [7:0]  m8, q8;
  logic [15:0] prod8;
  logic        start5, sm5, ready5, done5;
  logic [4:0]  m5, q5;
  logic [9:0]  prod5;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  booth_radix4_mult #(.DATA_WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .signed_mode(sm8),
    .multiplicand(m8), .multiplier(q8),
    .ready(ready8), .done(done8), .product(prod8)
  );

  booth_radix4_mult #(.DATA_WIDTH(5)) u_dut5 (
    .clk(clk), .rst(rst), .start(start5), .signed_mode(sm5),
    .multiplicand(m5), .multiplier(q5),
    .ready(ready5), .done(done5), .product(prod5)
  );

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic get_done(input bit d5);
    return d5 ? done5 : done8;
  endfunction

  function automatic logic get_ready(input bit d5);
    return d5 ? ready5 : ready8;
  endfunction

  function automatic logic [15:0] get_prod(input bit d5);
    return d5 ? {6'd0, prod5} : prod8;
  endfunction

  // Start an op at a negedge; returns at the negedge after the accepting edge.
  task automatic launch(input bit d5, input bit sm, input logic [7:0] m, input logic [7:0] q);
    @(negedge clk);
    if (d5) begin start5 = 1'b1; sm5 = sm; m5 = m[4:0]; q5 = q[4:0]; end
    else    begin start8 = 1'b1; sm8 = sm; m8 = m;      q8 = q;      end
    @(posedge clk);
    @(negedge clk);
    // Scramble operands and mode right after acceptance.
    if (d5) begin start5 = 1'b0; sm5 = ~sm; m5 = ~m[4:0]; q5 = 5'h0A; end
    else    begin start8 = 1'b0; sm8 = ~sm; m8 = ~m;      q8 = 8'h55; end
  endtask

  // From the negedge after an accepting edge, wait for done; edges counts from the accept edge.
  task automatic wait_done(input bit d5, output int edges, output int low);
    edges = 1;
    low   = 0;
    while (!get_done(d5) && edges < 20) begin
      if (!get_ready(d5)) low++;
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
  endtask

  task automatic run_op(input bit d5, input bit sm, input logic [7:0] m, input logic [7:0] q,
                        input logic [15:0] exp, input int exp_lat, input string tag);
    int edges, low;
    launch(d5, sm, m, q);
    wait_done(d5, edges, low);
    chk_eq({tag, "_done"}, 32'(get_done(d5)), 32'd1);
    chk_eq({tag, "_lat"}, edges, exp_lat);
    chk_eq({tag, "_rdy_low"}, low, exp_lat - 1);
    chk_eq({tag, "_prod"}, 32'(get_prod(d5)), 32'(exp));
    @(negedge clk);
    chk_eq({tag, "_pulse"}, 32'(get_done(d5)), 32'd0);
    chk_eq({tag, "_hold"}, 32'(get_prod(d5)), 32'(exp));
  endtask

  logic [7:0]  bm [3];
  logic [7:0]  bq [3];
  logic [15:0] be [3];

  initial begin
    int edges, low, extra;
    rst = 1'b1;
    start8 = 1'b0; sm8 = 1'b0; m8 = '0; q8 = '0;
    start5 = 1'b0; sm5 = 1'b0; m5 = '0; q5 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk_eq("rst_ready8", 32'(ready8), 32'd1);
    chk_eq("rst_done8", 32'(done8), 32'd0);
    chk_eq("rst_prod8", 32'(prod8), 32'd0);
    chk_eq("rst_ready5", 32'(ready5), 32'd1);
    chk_eq("rst_prod5", 32'(prod5), 32'd0);

    run_op(1'b0, 1'b1, 8'hF9, 8'h05, 16'hFFDD, 6, "s_m7x5");
    run_op(1'b0, 1'b0, 8'hFF, 8'hFF, 16'hFE01, 6, "u_ffxff");
    run_op(1'b0, 1'b1, 8'hFF, 8'hFF, 16'h0001, 6, "s_ffxff");
    run_op(1'b1, 1'b1, 8'h10, 8'h10, 16'h0100, 4, "w5_s_min");
    run_op(1'b1, 1'b0, 8'h1F, 8'h1F, 16'h03C1, 4, "w5_u_max");

    // Back-to-back with start held high; operands for the next op appear mid-CALC.
    bm[0] = 8'h80; bq[0] = 8'h80; be[0] = 16'h4000;
    bm[1] = 8'h80; bq[1] = 8'h7F; be[1] = 16'hC080;
    bm[2] = 8'h00; bq[2] = 8'h80; be[2] = 16'h0000;
    @(negedge clk);
    start8 = 1'b1; sm8 = 1'b1; m8 = bm[0]; q8 = bq[0];
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      if (i < 2) begin m8 = bm[i+1]; q8 = bq[i+1]; end
      else start8 = 1'b0;
      wait_done(1'b0, edges, low);
      chk_eq($sformatf("b2b%0d_prod", i), 32'(prod8), 32'(be[i]));
      chk_eq($sformatf("b2b%0d_gap", i), edges, 6);
      if (i < 2) begin
        @(posedge clk);
        @(negedge clk);
      end
    end

    // Start pulsed mid-CALC with other operands must be ignored.
    launch(1'b0, 1'b0, 8'h0C, 8'h0B);
    @(negedge clk);
    start8 = 1'b1; m8 = 8'hFF; q8 = 8'hFF; sm8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    edges = 0;
    while (!done8 && edges < 20) begin @(negedge clk); edges++; end
    chk_eq("ign_prod", 32'(prod8), 32'h0084);
    extra = 0;
    repeat (10) begin @(negedge clk); if (done8) extra++; end
    chk_eq("ign_extra_done", extra, 0);

    // Synchronous reset in the middle of CALC.
    launch(1'b0, 1'b1, 8'h12, 8'h34);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_eq("mid_rst_ready", 32'(ready8), 32'd1);
    chk_eq("mid_rst_prod", 32'(prod8), 32'd0);
    chk_eq("mid_rst_done", 32'(done8), 32'd0);
    extra = 0;
    repeat (8) begin @(negedge clk); if (done8) extra++; end
    chk_eq("mid_rst_no_done", extra, 0);
    run_op(1'b0, 1'b1, 8'h03, 8'hFC, 16'hFFF4, 6, "after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/booth_radix4_mult.md
Name: booth_radix4_mult

Overview:
Iterative radix-4 (modified Booth) multiplier. It is the parametrised successor to the team's radix-2 Booth unit: it retires two multiplier bits per cycle and supports a runtime signed/unsigned mode. It adds a start/ready/done handshake so it can sit behind the ALU datapath controller as a multi-cycle execution unit. Operands are latched at start and the result is held until the next operation.

Parameters:
DATA_WIDTH, 8, operand width W in bits; must be >= 2; odd values allowed.
STEPS, derived (localparam), XW/2, where XW = W+2 if W is even and W+1 if W is odd (XW is even and >= W+1).
CNT_WIDTH, derived (localparam), $clog2(STEPS+1), width of the step counter.

Ports:
clk  input  1  system clock; all logic is rising-edge.
rst  input  1  synchronous, active-high reset.
start  input  1  request; accepted only when ready=1.
signed_mode  input  1  1 = two's-complement operands; 0 = unsigned. Sampled with start.
multiplicand  input  W  operand M, sampled when start is accepted.
multiplier  input  W  operand Q, sampled when start is accepted.
ready  output  1  1 in IDLE and DONE; 0 while computing.
done  output  1  single-cycle pulse: product is valid and new.
product  output  2W  result register; holds the last result until the next accepted start.

Behaviour:
- Reset (synchronous, rst=1 at an edge): state=IDLE, ready=1, done=0, product=0, internal AC/Q/q-1/counter=0. Applies from any state; an in-flight operation is discarded with no done pulse.
- States: IDLE, CALC, DONE.
  - IDLE: if start=1, latch operands and go to CALC.
  - CALC: perform one step per cycle. After step STEPS, go to DONE.
  - DONE: one cycle, done=1. If start=1, accept it (back-to-back) and go to CALC; otherwise go to IDLE.
- Start qualification: start is accepted when start & ready. start while ready=0 is ignored; it is not queued.
- Load on accept:
  - M and Q are extended to XW bits: sign-extended if signed_mode=1, zero-extended otherwise.
  - AC (XW+1 bits) = 0, Q register = extended Q, q-1 = 0, counter = 0.
- Each CALC step:
  - Examine {Q[1],Q[0],q-1}.
  - 000/111: add 0. 001/010: add +M. 011: add +2M. 100: add -2M. 101/110: add -M.
  - M and 2M are sign-extended to XW+1 bits for the add; two's-complement wrap within XW+1 bits.
  - Then arithmetic-shift {AC,Q,q-1} right by 2 (AC MSB replicated).
  - Increment counter.
- Result: on the CALC->DONE transition, product <= low 2W bits of {AC,Q}. This equals the exact product, mod 2^(2W) for its sign.
- Latency: done is high in the cycle after STEPS+1 rising edges following the accepting edge. For W=8 (XW=10, STEPS=5) that is 6 edges; for W=5 (XW=6, STEPS=3) it is 4 edges. Throughput is one result per STEPS+1 cycles with back-to-back starts.
- ready=0 for exactly STEPS cycles per operation.
- Operand inputs may change freely after the accepting edge without affecting the result.
- product does not change except on the CALC->DONE transition or on reset.
- Corner cases:
  - Most-negative signed operands and all-ones unsigned operands must be exact.
  - signed_mode is taken only from the accept cycle.

Test Plan:
- W=8, signed_mode=1, M=-7 (0xF9), Q=5 -> done after 6 edges, product=0xFFDD (-35); ready low for exactly 5 cycles.
- W=8, signed_mode=0, M=0xFF, Q=0xFF -> product=0xFE01 (65025). Same operands with signed_mode=1 -> product=0x0001.
- W=8, signed: M=0x80, Q=0x80 -> 0x4000. Then M=0x80, Q=0x7F -> 0xC080. Then M=0, Q=0x80 -> 0x0000, with done pulses back-to-back every 6 cycles while start is held high.
- W=5, signed: M=-16, Q=-16 -> product=10'h100, latency 4 edges. Unsigned: M=31, Q=31 -> 10'h3C1.
- Start pulsed during CALC with different operands -> ignored; first result unchanged; no extra done. Change operand inputs mid-CALC -> result unaffected.
- Assert rst for one cycle in the middle of CALC -> next cycle state=IDLE, ready=1, product=0, no done pulse. A following start computes 3*-4 = 0xFFF4 correctly.
